// File: rtl/csa_stream_accumulator_pkg.sv
// Shared types and sizing helpers for the carry-save stream accumulator.
// Operand/result widths and the controller state encoding live here.
package csa_pkg;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_MAX_OPS = 8;

  // Plain 2-bit encoding keeps the state register compatible with older flows
  typedef logic [1:0] state_t;

  localparam state_t ACCUM   = 2'd0;
  localparam state_t RESOLVE = 2'd1;
  localparam state_t DONE    = 2'd2;

  function automatic int calc_out_w(input int width, input int max_ops);
    return width + $clog2(max_ops);
  endfunction

  function automatic int calc_cnt_w(input int max_ops);
    return $clog2(max_ops) + 1;
  endfunction

endpackage

// File: rtl/csa_stream_accumulator_if.sv
// Operand input stream and result output stream of the accumulator,
// bundled so the producer/consumer side and the block side share one port.
interface csa_stream_accumulator_if
  import csa_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MAX_OPS = DEF_MAX_OPS
);

  localparam int CNT_W = calc_cnt_w(MAX_OPS);
  localparam int OUT_W = calc_out_w(WIDTH, MAX_OPS);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;

  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_forced;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_forced
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_forced
  );

endinterface

// File: rtl/csa_stream_accumulator_row.sv
// One row of full adders used as a 3:2 compressor; the carry output is
// returned unshifted so the caller decides how to weight it.
module csa_row
  import csa_pkg::*;
#(
  parameter int W = calc_out_w(DEF_WIDTH, DEF_MAX_OPS)
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] s,
  output logic [W-1:0] c_out
);

  assign s     = a ^ b ^ c;
  assign c_out = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_stream_accumulator.sv
// Multi-operand adder: running total kept as sum+carry vectors, converted to
// binary by a bit-serial adder once the packet ends, then offered downstream.
module csa_stream_accumulator
  import csa_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MAX_OPS = DEF_MAX_OPS
) (
  input logic clk,
  input logic rst,
  csa_stream_accumulator_if.slave bus
);

  localparam int CNT_W = calc_cnt_w(MAX_OPS);
  localparam int OUT_W = calc_out_w(WIDTH, MAX_OPS);
  localparam int IDX_W = $clog2(OUT_W);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_W - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_OPS - 1);

  state_t           state_r;
  logic [OUT_W-1:0] sum_r;
  logic [OUT_W-1:0] carry_r;
  logic [OUT_W-1:0] res_r;
  logic [CNT_W-1:0] count_r;
  logic [IDX_W-1:0] bit_idx;
  logic             cy_r;
  logic             forced_r;

  logic             out_valid_r;
  logic [OUT_W-1:0] out_data_r;
  logic [CNT_W-1:0] out_count_r;
  logic             out_forced_r;

  logic [OUT_W-1:0] data_ext;
  logic [OUT_W-1:0] row_s;
  logic [OUT_W-1:0] row_c;
  logic             unused_row_c_msb;
  logic             accept;
  logic             final_beat;
  logic             res_bit;
  logic             res_cy;

  assign data_ext   = {{(OUT_W - WIDTH){1'b0}}, bus.in_data};
  assign accept     = bus.in_valid && (state_r == ACCUM);
  assign final_beat = bus.in_last || (count_r == LAST_CNT);

  // The carry vector's top bit would be shifted out; the bound on MAX_OPS keeps it zero
  assign unused_row_c_msb = row_c[OUT_W-1];

  assign res_bit = sum_r[0] ^ carry_r[0] ^ cy_r;
  assign res_cy  = (sum_r[0] & carry_r[0]) | (cy_r & (sum_r[0] ^ carry_r[0]));

  csa_row #(.W(OUT_W)) u_row (
    .a     (sum_r),
    .b     (carry_r),
    .c     (data_ext),
    .s     (row_s),
    .c_out (row_c)
  );

  assign bus.in_ready   = (state_r == ACCUM);
  assign bus.out_valid  = out_valid_r;
  assign bus.out_data   = out_data_r;
  assign bus.out_count  = out_count_r;
  assign bus.out_forced = out_forced_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ACCUM;
      sum_r        <= '0;
      carry_r      <= '0;
      res_r        <= '0;
      count_r      <= '0;
      bit_idx      <= '0;
      cy_r         <= 1'b0;
      forced_r     <= 1'b0;
      out_valid_r  <= 1'b0;
      out_data_r   <= '0;
      out_count_r  <= '0;
      out_forced_r <= 1'b0;
    end else begin
      case (state_r)
        ACCUM: begin
          if (accept) begin
            sum_r   <= row_s;
            carry_r <= {row_c[OUT_W-2:0], 1'b0};
            count_r <= count_r + 1'b1;
            if (final_beat) begin
              state_r  <= RESOLVE;
              forced_r <= !bus.in_last;
              cy_r     <= 1'b0;
              bit_idx  <= '0;
            end
          end
        end

        // Both vectors shift right so the adder always works on bit 0
        RESOLVE: begin
          res_r   <= {res_bit, res_r[OUT_W-1:1]};
          cy_r    <= res_cy;
          sum_r   <= {1'b0, sum_r[OUT_W-1:1]};
          carry_r <= {1'b0, carry_r[OUT_W-1:1]};
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == LAST_IDX) begin
            state_r <= DONE;
          end
        end

        // First DONE cycle registers the result; valid then holds until taken
        DONE: begin
          if (!out_valid_r) begin
            out_valid_r  <= 1'b1;
            out_data_r   <= res_r;
            out_count_r  <= count_r;
            out_forced_r <= forced_r;
          end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= ACCUM;
            sum_r       <= '0;
            carry_r     <= '0;
            count_r     <= '0;
            forced_r    <= 1'b0;
          end
        end

        default: begin
          state_r <= ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Directed-vector bench for csa_stream_accumulator; a monitor process checks
// each delivered result against a scoreboard filled by the stimulus side.
module tb_csa_stream_accumulator;
  import csa_pkg::*;

  localparam int WIDTH   = 4;
  localparam int MAX_OPS = 8;
  localparam int OUT_W   = calc_out_w(WIDTH, MAX_OPS);

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  csa_stream_accumulator_if #(.WIDTH(WIDTH), .MAX_OPS(MAX_OPS)) bus ();

  csa_stream_accumulator #(.WIDTH(WIDTH), .MAX_OPS(MAX_OPS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int data;
    int count;
    int forced;
    int rise;
  } exp_t;

  exp_t sb[$];

  int errors       = 0;
  int checks       = 0;
  int cyc          = 0;
  int drv_tok      = 0;
  int abort_tok    = 0;
  int mon_tok      = 0;
  int last_hs_edge = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got timeout, expected event within bound", name);
  endtask

  // Presents one beat and holds it until the block takes it
  task automatic apply_stimulus(input int d, input bit last, output int acc_edge);
    bit taken;
    taken        = 1'b0;
    acc_edge     = -1;
    bus.in_valid = 1'b1;
    bus.in_data  = WIDTH'(d);
    bus.in_last  = last;
    for (int k = 0; k < 100 && !taken; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        acc_edge = cyc;
        taken    = 1'b1;
      end
    end
    if (!taken) fail_now("accept_timeout");
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_packet(input int n, input int vals [MAX_OPS], input bit with_last,
                             input int exp_data, input int exp_forced, input bit keep,
                             output int acc_edge);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      apply_stimulus(vals[i], with_last && (i == n - 1), acc_edge);
    end
    drv_tok++;
    if (keep) begin
      e.data   = exp_data;
      e.count  = n;
      e.forced = exp_forced;
      e.rise   = acc_edge + OUT_W + 1;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < 100 && !idle; k++) begin
      @(posedge clk);
      #1;
      idle = (drv_tok == mon_tok + abort_tok) && (sb.size() == 0);
    end
    if (!idle) fail_now("drain_timeout");
  endtask

  // Monitor: result checks, valid latency, and in_ready around each packet
  initial begin
    bit   prev_valid;
    bit   hs_check;
    int   rise;
    exp_t e;
    prev_valid = 1'b0;
    hs_check   = 1'b0;
    rise       = -1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (hs_check) begin
          check_output("in_ready_after_handshake", int'(bus.in_ready), 1);
          hs_check = 1'b0;
        end else if (drv_tok > mon_tok + abort_tok) begin
          check_output("in_ready_while_busy", int'(bus.in_ready), 0);
        end
        if (bus.out_valid && !prev_valid) rise = cyc;
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_result: got data %0d, expected no result", bus.out_data);
          end else begin
            e = sb.pop_front();
            check_output("out_data", int'(bus.out_data), e.data);
            check_output("out_count", int'(bus.out_count), e.count);
            check_output("out_forced", int'(bus.out_forced), e.forced);
            check_output("valid_latency_edge", rise, e.rise);
          end
          mon_tok++;
          last_hs_edge = cyc + 1;
          hs_check     = 1'b1;
        end
      end
      prev_valid = bus.out_valid;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc;
    bit seen;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check_output("reset_in_ready", int'(bus.in_ready), 1);
    check_output("reset_out_valid", int'(bus.out_valid), 0);
    check_output("reset_out_data", int'(bus.out_data), 0);
    check_output("reset_out_count", int'(bus.out_count), 0);
    check_output("reset_out_forced", int'(bus.out_forced), 0);

    send_packet(3, '{15, 13, 11, 0, 0, 0, 0, 0}, 1'b1, 39, 0, 1'b1, acc);

    send_packet(3, '{11, 13, 11, 0, 0, 0, 0, 0}, 1'b1, 35, 0, 1'b1, acc);
    send_packet(3, '{13, 13, 11, 0, 0, 0, 0, 0}, 1'b1, 37, 0, 1'b1, acc);
    send_packet(3, '{11, 13, 10, 0, 0, 0, 0, 0}, 1'b1, 34, 0, 1'b1, acc);

    send_packet(1, '{9, 0, 0, 0, 0, 0, 0, 0}, 1'b1, 9, 0, 1'b1, acc);

    // Ninth beat follows immediately and may only land after the handshake
    send_packet(8, '{15, 15, 15, 15, 15, 15, 15, 15}, 1'b0, 120, 1, 1'b1, acc);
    send_packet(1, '{4, 0, 0, 0, 0, 0, 0, 0}, 1'b1, 4, 0, 1'b1, acc);
    check_output("ninth_beat_accept_edge", acc, last_hs_edge + 1);
    drain();

    bus.out_ready = 1'b0;
    send_packet(2, '{5, 6, 0, 0, 0, 0, 0, 0}, 1'b1, 11, 0, 1'b1, acc);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'd7;
    bus.in_last  = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = bus.out_valid;
    end
    if (!seen) fail_now("stall_valid_timeout");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_output("stall_out_valid", int'(bus.out_valid), 1);
      check_output("stall_out_data", int'(bus.out_data), 11);
      check_output("stall_out_count", int'(bus.out_count), 2);
      check_output("stall_in_ready", int'(bus.in_ready), 0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    send_packet(1, '{7, 0, 0, 0, 0, 0, 0, 0}, 1'b1, 7, 0, 1'b1, acc);
    drain();

    // Reset lands in the third resolve cycle; that packet must vanish
    send_packet(2, '{15, 15, 0, 0, 0, 0, 0, 0}, 1'b1, 30, 0, 1'b0, acc);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    abort_tok++;
    check_output("abort_out_valid", int'(bus.out_valid), 0);
    check_output("abort_out_data", int'(bus.out_data), 0);
    check_output("abort_out_count", int'(bus.out_count), 0);
    check_output("abort_out_forced", int'(bus.out_forced), 0);
    check_output("abort_in_ready", int'(bus.in_ready), 1);
    repeat (15) @(posedge clk);
    #1;

    send_packet(2, '{1, 2, 0, 0, 0, 0, 0, 0}, 1'b1, 3, 0, 1'b1, acc);
    drain();
    check_output("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csa_stream_accumulator.md
Name: csa_stream_accumulator

Overview:
- Sequential multi-operand adder built on carry-save reduction.
- Accepts a stream of unsigned operands over a valid/ready interface and keeps the running total in redundant form: a sum vector plus a carry vector, one 3:2 compression per accepted beat.
- On the last beat, a bit-serial carry-propagate stage converts the redundant total to binary.
- Presents the binary result on a valid/ready output port, ahead of downstream arithmetic.

Parameters:
- WIDTH, 4, operand width in bits.
- MAX_OPS, 8, maximum operands per packet (power of two, ≥2).
- CNT_W (localparam), $clog2(MAX_OPS)+1, width of the operand counter.
- OUT_W (localparam), WIDTH+$clog2(MAX_OPS), result width; 7 at defaults.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept an operand.
- in_data  in  WIDTH  unsigned operand.
- in_last  in  1  marks the final operand of a packet.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  OUT_W  binary sum of the packet.
- out_count  out  CNT_W  number of operands summed.
- out_forced  out  1  packet was terminated by reaching MAX_OPS without in_last.

Behaviour:
- Reset: one clk edge with rst=1.
  - state=ACCUM; sum_r=0, carry_r=0, count=0, bit index=0.
  - in_ready=1, out_valid=0, out_data=0, out_count=0, out_forced=0.
  - rst overrides everything, including mid-RESOLVE and mid-DONE; the partial packet is discarded.
- States: ACCUM -> RESOLVE -> DONE -> ACCUM.
- ACCUM:
  - in_ready=1.
  - A beat is accepted when in_valid && in_ready.
  - On acceptance: sum_r <= s and carry_r <= c<<1, where s,c = 3:2 compression of (sum_r, carry_r, zero-extended in_data) to OUT_W bits. Bits shifted past OUT_W are dropped; no overflow is possible within MAX_OPS operands.
  - count increments on every accepted beat.
  - Go to RESOLVE if in_last=1, or if the accepted beat is number MAX_OPS. The forced flag is set when in_last=0 on that beat.
- RESOLVE:
  - in_ready=0.
  - Bit-serial addition of sum_r and carry_r, LSB first, one result bit per cycle, with a 1-bit carry flop cleared on entry.
  - Exactly OUT_W cycles, then DONE.
  - out_valid rises exactly OUT_W+1 edges after the accepting edge.
- DONE:
  - out_valid=1; out_data, out_count and out_forced are held stable while out_ready=0.
  - On out_valid && out_ready: out_valid goes to 0, state goes to ACCUM, and sum_r, carry_r and count are cleared in the same edge.
  - in_ready rises on the following cycle; there is no same-cycle bypass.
- in_valid in RESOLVE or DONE is ignored and not consumed; the upstream holds it.
- in_data and in_last are sampled only on the accepting edge.
- A single-operand packet (in_last on the first beat) is legal; the result equals that operand.
- Throughput: one packet per (N + OUT_W + 2) cycles minimum, with out_ready held high.

Decomposition:
- Shared package csa_pkg:
  - state enum {ACCUM, RESOLVE, DONE};
  - WIDTH/MAX_OPS defaults;
  - function for the OUT_W derivation.
- One sub-module, csa_row:
  - purely combinational OUT_W-bit 3:2 compressor row;
  - inputs a, b, c; outputs s, c_out (unshifted);
  - instantiated once.
- FSM, counter and serial resolver stay in the top.

Test Plan:
- 3-operand packet 15,13,11 (last on 11), out_ready=1 -> out_data=39, out_count=3, out_forced=0; out_valid 8 edges after the last accept.
- Back-to-back packets {11,13,11}, {13,13,11}, {11,13,10} -> 35, 37, 34 in order.
  - in_ready stays 0 from the last accept until the cycle after each result handshake.
- Single beat 9 with in_last=1 -> out_data=9, out_count=1.
- Eight beats of 15, in_last never set -> out_data=120, out_count=8, out_forced=1.
  - A ninth beat presented meanwhile is not accepted until ACCUM is re-entered.
- out_ready held 0 for 5 cycles in DONE -> out_valid stays 1 and outputs stay stable.
  - in_valid is ignored throughout; the result transfers on the edge where out_ready=1.
- Assert rst during cycle 3 of RESOLVE for packet {15,15} -> all outputs return to reset values next edge, no result is emitted.
  - A following packet {1,2} yields 3.
